// File: rtl/scramble_sequencer.sv
// Scramble sequencer: latches a random seed word and issues it as a stream of
// 2-bit moves over valid/ready, then pulses done. Optional: SCRAMBLE_NO_BACKTRACK_EN.
module scramble_sequencer #(
   parameter int SEED_W    = 32,
   parameter int MOVE_W    = 2,
   parameter int NUM_MOVES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SEED_W-1:0] seed,
   output logic [MOVE_W-1:0] move_dir,
   output logic              move_valid,
   input  logic              move_ready,
   output logic [4:0]        move_idx,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = 5;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [SEED_W-1:0]  shreg_q, shreg_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [MOVE_W-1:0]  raw_dir;
   logic [MOVE_W-1:0]  dir_c;
   logic               fire;
   logic               last;

   assign raw_dir = shreg_q[MOVE_W-1:0];
   assign fire    = move_valid && move_ready;
   assign last    = (idx_q == IDX_W'(NUM_MOVES - 1));

`ifdef SCRAMBLE_NO_BACKTRACK_EN
   localparam logic [MOVE_W-1:0] UNDO_X = MOVE_W'(1);
   localparam logic [MOVE_W-1:0] PERP_X = MOVE_W'(2);

   logic [MOVE_W-1:0] prev_q;

   // A move that would undo the previous one is turned to the perpendicular axis.
   assign dir_c = ((idx_q != '0) && (raw_dir == (prev_q ^ UNDO_X))) ? (raw_dir ^ PERP_X) : raw_dir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prev_q <= '0;
      else if (fire)
         prev_q <= dir_c;
   end
`else
   assign dir_c = raw_dir;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d = seed;
               idx_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (fire) begin
               shreg_d = shreg_q >> MOVE_W;
               // Index stays on the final move through DONE, cleared on the way to IDLE.
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      move_valid = 1'b0;
      move_dir   = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_ISSUE: begin
            move_valid = 1'b1;
            move_dir   = dir_c;
            busy       = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign move_idx = idx_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Scoreboard bench for scramble_sequencer: stimulus pushes expected moves,
// a negedge monitor pops and compares on every handshake and checks done.
module tb_scramble_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] seed;
   logic [1:0]  move_dir;
   logic        move_valid;
   logic        move_ready;
   logic [4:0]  move_idx;
   logic        busy;
   logic        done;

   typedef struct {
      logic [1:0] dir;
      logic [4:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   done_cnt = 0;

   scramble_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .seed       (seed),
      .move_dir   (move_dir),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .move_idx   (move_idx),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] d, input int i);
      exp_t e;
      e.dir = d;
      e.idx = 5'(i);
      exp_q.push_back(e);
   endtask

   // Reference decode of a seed into the move stream.
   task automatic push_seq(input logic [31:0] s);
      logic [1:0] prev;
      logic [1:0] raw;
      logic [1:0] d;
      prev = 2'd0;
      for (int i = 0; i < 16; i++) begin
         raw = s[2*i +: 2];
         d   = raw;
`ifdef SCRAMBLE_NO_BACKTRACK_EN
         if (i > 0 && raw == (prev ^ 2'b01)) d = raw ^ 2'b10;
`endif
         prev = d;
         push(d, i);
      end
   endtask

   task automatic issue_start(input logic [31:0] s);
      seed  = s;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         tick;
         n++;
      end
      chk(name, done_cnt - d0, 1);
   endtask

   // Monitor: compare each accepted move, and check done only after the last one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (move_valid && move_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_move: got dir=%0d idx=%0d expected none", move_dir, move_idx);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("move_dir", {30'd0, move_dir}, {30'd0, e.dir});
               chk("move_idx", {27'd0, move_idx}, {27'd0, e.idx});
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_queue_empty", exp_q.size(), 0);
            chk("done_no_valid", {31'd0, move_valid}, 32'd0);
         end
      end
   end

   initial begin
      int n;
      int d0;
      rst_n      = 1'b0;
      start      = 1'b0;
      seed       = 32'd0;
      move_ready = 1'b0;
      #12;
      chk("rst_valid", {31'd0, move_valid}, 0);
      chk("rst_busy",  {31'd0, busy}, 0);
      chk("rst_done",  {31'd0, done}, 0);
      chk("rst_idx",   {27'd0, move_idx}, 0);
      chk("rst_dir",   {30'd0, move_dir}, 0);
      tick;
      rst_n = 1'b1;
      tick;

      // 1: seed 0x1B, ready always high, back-to-back moves
      push(2'd3, 0); push(2'd2, 1); push(2'd1, 2); push(2'd0, 3);
      for (int i = 4; i < 16; i++) push(2'd0, i);
      move_ready = 1'b1;
      issue_start(32'h0000_001B);
      chk("t1_first_valid", {31'd0, move_valid}, 1);
      chk("t1_first_busy",  {31'd0, busy}, 1);
      chk("t1_first_dir",   {30'd0, move_dir}, 3);
      n = 0;
      while (!done && n < 40) begin tick; n++; end
      chk("t1_cycles_to_done", n, 16);
      tick;
      chk("t1_busy_after", {31'd0, busy}, 0);
      chk("t1_done_after", {31'd0, done}, 0);

      // 2: back-pressure on the first move
      move_ready = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 16; i++) push(2'd3, i);
      issue_start(32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", {31'd0, move_valid}, 1);
         chk("t2_hold_dir",   {30'd0, move_dir}, 3);
         chk("t2_hold_idx",   {27'd0, move_idx}, 0);
         tick;
      end
      move_ready = 1'b1;
      wait_done("t2_done", 60);
      tick; tick;
      chk("t2_done_count", done_cnt - d0, 1);

      // 3: start re-asserted mid-sequence is ignored
      d0 = done_cnt;
      push_seq(32'h1234_5678);
      issue_start(32'h1234_5678);
      n = 0;
      while (move_idx != 5'd7 && n < 40) begin tick; n++; end
      chk("t3_reach_idx7", {27'd0, move_idx}, 7);
      seed  = 32'hA5A5_0F0F;
      start = 1'b1;
      tick; tick;
      start = 1'b0;
      wait_done("t3_done", 60);
      tick; tick; tick;
      chk("t3_done_count", done_cnt - d0, 1);
      chk("t3_idle", {31'd0, busy}, 0);

      // 4: reset mid-sequence discards the remainder
      d0 = done_cnt;
      push_seq(32'h1234_5678);
      issue_start(32'h1234_5678);
      n = 0;
      while (move_idx != 5'd9 && n < 40) begin tick; n++; end
      chk("t4_reach_idx9", {27'd0, move_idx}, 9);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", {31'd0, move_valid}, 0);
      chk("t4_rst_busy",  {31'd0, busy}, 0);
      chk("t4_rst_idx",   {27'd0, move_idx}, 0);
      chk("t4_rst_dir",   {30'd0, move_dir}, 0);
      chk("t4_rst_done",  {31'd0, done}, 0);
      exp_q.delete();
      tick; tick;
      rst_n = 1'b1;
      tick;
      chk("t4_no_done", done_cnt - d0, 0);
      push(2'd2, 0);
      for (int i = 1; i < 16; i++) push(2'd0, i);
      issue_start(32'h0000_0002);
      chk("t4_new_first_dir", {30'd0, move_dir}, 2);
      wait_done("t4_done", 40);
      tick;

      // 5: seed 0x4 -- direct undo on move 1
      push(2'd0, 0);
`ifdef SCRAMBLE_NO_BACKTRACK_EN
      push(2'd3, 1);
`else
      push(2'd1, 1);
`endif
      for (int i = 2; i < 16; i++) push(2'd0, i);
      issue_start(32'h0000_0004);
      wait_done("t5_done", 40);
      tick;

      // 6: seed 0 with ready toggling every cycle
      d0 = done_cnt;
      for (int i = 0; i < 16; i++) push(2'd0, i);
      move_ready = 1'b1;
      issue_start(32'h0000_0000);
      n = 0;
      while (!done && n < 80) begin
         tick;
         n++;
         move_ready = ~move_ready;
      end
      chk("t6_cycles_to_done", n, 31);
      tick; tick; tick;
      chk("t6_done_count", done_cnt - d0, 1);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
